dcache_flush_seq: RTL and testbench

DCACHE_FLUSH_SEQ -- requirements
Module: dcache_flush_seq

---
 rtl/ariane_pkg.sv | 18 +
 rtl/cva6_config_pkg.sv | 11 +
 rtl/flush_wdog.sv | 30 +++
 rtl/dcache_flush_seq.sv | 75 +++++++
 tb/tb_dcache_flush_seq.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ariane_pkg.sv
// ariane_pkg: shared CMO opcode and flush-sequencer state types
package ariane_pkg;

    typedef enum logic [1:0] {
        FLUSH_NONE      = 2'd0,
        FLUSH_ALL       = 2'd1,
        FLUSH_INVAL_ALL = 2'd2
    } flush_op_t;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        REQ,
        WAIT_RSP,
        ACK
    } flush_state_t;

endpackage

// File: rtl/cva6_config_pkg.sv
// cva6_config_pkg: user configuration record consumed by the data-cache flush sequencer
package cva6_config_pkg;

    typedef struct packed {
        bit DcacheFlushOnFence;
        bit DcacheInvalidateOnFlush;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg = '{DcacheFlushOnFence: 1'b1, DcacheInvalidateOnFlush: 1'b0};

endpackage

// File: rtl/flush_wdog.sv
// flush_wdog: saturating wait counter with a sticky overdue flag
// Ports: clk_i/rst_ni clock and async active-low reset; en_i counts one cycle;
// clr_i restarts the count; limit_i overdue threshold; flag_o sticky overdue flag.
module flush_wdog (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [31:0] limit_i,
    output logic        flag_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_inc;

    assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 32'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            flag_o <= 1'b0;
        end else begin
            if (clr_i) cnt_q <= '0;
            else if (en_i) cnt_q <= cnt_inc;
            // flag rises on the edge where the count reaches the limit
            if (en_i && cnt_inc >= limit_i) flag_o <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_flush_seq.sv
// dcache_flush_seq: fence/flush sequencer issuing a whole-cache CMO to the HPDcache
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i/flush_ack_o request
// and one-cycle completion; st_empty_i store path drained; cmo_req_valid_o/
// cmo_req_ready_i/cmo_req_op_o CMO request; cmo_rsp_valid_i CMO completion;
// busy_o not idle; timeout_o sticky overdue; proto_err_o sticky unexpected response.
module dcache_flush_seq
    import ariane_pkg::*;
#(
    parameter cva6_config_pkg::cva6_cfg_t CVA6Cfg       = cva6_config_pkg::cva6_cfg,
    parameter int unsigned                TimeoutCycles = 4096
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      flush_i,
    output logic      flush_ack_o,
    input  logic      st_empty_i,
    output logic      cmo_req_valid_o,
    input  logic      cmo_req_ready_i,
    output flush_op_t cmo_req_op_o,
    input  logic      cmo_rsp_valid_i,
    output logic      busy_o,
    output logic      timeout_o,
    output logic      proto_err_o
);

    flush_state_t state_q;
    flush_state_t state_d;
    flush_op_t    req_op;
    logic         wait_clr;

    assign req_op   = CVA6Cfg.DcacheInvalidateOnFlush ? FLUSH_INVAL_ALL : FLUSH_ALL;
    assign wait_clr = (state_q != WAIT_RSP) && (state_d == WAIT_RSP);

    // cmo_req_valid_o is 1 throughout REQ, so ready alone completes the handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (flush_i) state_d = CVA6Cfg.DcacheFlushOnFence ? DRAIN : ACK;
            DRAIN:    if (st_empty_i) state_d = REQ;
            REQ:      if (cmo_req_ready_i) state_d = WAIT_RSP;
            WAIT_RSP: if (cmo_rsp_valid_i) state_d = ACK;
            ACK:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // outputs are registered from the next state so they align with state_q
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            cmo_req_valid_o <= 1'b0;
            cmo_req_op_o    <= FLUSH_NONE;
            flush_ack_o     <= 1'b0;
            busy_o          <= 1'b0;
            proto_err_o     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cmo_req_valid_o <= state_d == REQ;
            cmo_req_op_o    <= state_d == REQ ? req_op : FLUSH_NONE;
            flush_ack_o     <= state_d == ACK;
            busy_o          <= state_d != IDLE;
            proto_err_o     <= proto_err_o | (cmo_rsp_valid_i && state_q != WAIT_RSP);
        end
    end

    flush_wdog u_wdog (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (state_q == WAIT_RSP),
        .clr_i   (wait_clr),
        .limit_i (32'(TimeoutCycles)),
        .flag_o  (timeout_o)
    );

endmodule

// File: tb/tb_dcache_flush_seq.sv
// tb_dcache_flush_seq: three configurations of the flush sequencer against a reference model
module tb_dcache_flush_seq;
    import ariane_pkg::*;

    localparam int       TMO = 8;
    localparam bit [2:0] FOF = 3'b011;
    localparam bit [2:0] INV = 3'b010;

    typedef struct packed {
        logic       f;
        logic       e;
        logic       r;
        logic       s;
        logic       v;
        logic [1:0] op;
        logic       a;
        logic       b;
    } vec_t;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      flush = 1'b0;
    logic      st_empty = 1'b0;
    logic      rdy = 1'b0;
    logic      rsp = 1'b0;
    logic      valid [3];
    logic      ack [3];
    logic      busy [3];
    logic      tmo [3];
    logic      perr [3];
    flush_op_t op [3];

    int total = 0;
    int bad = 0;
    int hs = 0;
    bit d2_valid_seen = 1'b0;

    bit m_drain [3];
    bit m_req [3];
    bit m_wait [3];
    bit m_ack [3];
    bit m_tmo [3];
    bit m_perr [3];
    int m_wcnt [3];

    vec_t tbl [7];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dcache_flush_seq #(
            .CVA6Cfg(cva6_config_pkg::cva6_cfg_t'{DcacheFlushOnFence: FOF[g], DcacheInvalidateOnFlush: INV[g]}),
            .TimeoutCycles(TMO)
        ) u_dut (
            .clk_i           (clk),
            .rst_ni          (rst_n),
            .flush_i         (flush),
            .flush_ack_o     (ack[g]),
            .st_empty_i      (st_empty),
            .cmo_req_valid_o (valid[g]),
            .cmo_req_ready_i (rdy),
            .cmo_req_op_o    (op[g]),
            .cmo_rsp_valid_i (rsp),
            .busy_o          (busy[g]),
            .timeout_o       (tmo[g]),
            .proto_err_o     (perr[g])
        );
    end

    always @(posedge clk) begin
        if (valid[0] && rdy) hs <= hs + 1;
        if (valid[2]) d2_valid_seen <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dut_vec(input int i);
        return {valid[i], op[i], ack[i], busy[i], tmo[i], perr[i]};
    endfunction

    function automatic logic [6:0] model_vec(input int i);
        logic [1:0] mop;
        mop = m_req[i] ? (INV[i] ? 2'd2 : 2'd1) : 2'd0;
        return {m_req[i], mop, m_ack[i], m_drain[i] | m_req[i] | m_wait[i] | m_ack[i], m_tmo[i], m_perr[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_drain[i] = 0; m_req[i] = 0; m_wait[i] = 0; m_ack[i] = 0;
            m_tmo[i] = 0; m_perr[i] = 0; m_wcnt[i] = 0;
        end
    endtask

    // one flush at a time: idle -> (drain -> request -> wait for response) or straight to ack
    task automatic model_step(input logic f, input logic e, input logic r, input logic s);
        for (int i = 0; i < 3; i++) begin
            bit idle, nd, nr, nw, na;
            idle = !(m_drain[i] || m_req[i] || m_wait[i] || m_ack[i]);
            nd = 0; nr = 0; nw = 0; na = 0;
            if (s && !m_wait[i]) m_perr[i] = 1;
            if (idle && f) begin
                if (FOF[i]) nd = 1;
                else na = 1;
            end
            if (m_drain[i]) begin
                if (e) nr = 1;
                else nd = 1;
            end
            if (m_req[i]) begin
                if (r) begin
                    nw = 1;
                    m_wcnt[i] = 0;
                end else nr = 1;
            end
            if (m_wait[i]) begin
                m_wcnt[i]++;
                if (m_wcnt[i] >= TMO) m_tmo[i] = 1;
                if (s) na = 1;
                else nw = 1;
            end
            m_drain[i] = nd; m_req[i] = nr; m_wait[i] = nw; m_ack[i] = na;
        end
    endtask

    task automatic tick(input logic f, input logic e, input logic r, input logic s);
        flush = f; st_empty = e; rdy = r; rsp = s;
        @(posedge clk);
        if (rst_n) model_step(f, e, r, s);
        else model_reset();
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("model_d%0d", i), 32'(dut_vec(i)), 32'(model_vec(i)));
    endtask

    initial begin
        bit ack_seen;
        tbl[0] = 9'b1110_0_00_0_1;
        tbl[1] = 9'b0110_1_01_0_1;
        tbl[2] = 9'b0110_0_00_0_1;
        tbl[3] = 9'b0110_0_00_0_1;
        tbl[4] = 9'b0111_0_00_1_1;
        tbl[5] = 9'b1110_0_00_0_0;
        tbl[6] = 9'b0110_0_00_0_0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("reset_d%0d", i), 32'(dut_vec(i)), 32'd0);
        rst_n = 1'b1;

        // basic flush on the first edge after reset release
        for (int c = 0; c < 7; c++) begin
            tick(tbl[c].f, tbl[c].e, tbl[c].r, tbl[c].s);
            chk($sformatf("tbl_c%0d", c), {valid[0], op[0], ack[0], busy[0]}, {tbl[c].v, tbl[c].op, tbl[c].a, tbl[c].b});
        end

        // back-pressure: ready low for 10 cycles in REQ
        hs = 0;
        tick(1, 1, 0, 0);
        tick(0, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid_op", {valid[0], op[0]}, {1'b1, FLUSH_ALL});
            tick(0, 1, 0, 0);
        end
        tick(0, 1, 1, 0);
        tick(0, 1, 0, 1);
        chk("bp_ack", 32'(ack[0]), 32'd1);
        tick(0, 1, 0, 0);
        chk("bp_handshakes", hs, 1);

        // long drain with invalidating configuration
        tick(1, 0, 1, 0);
        for (int k = 0; k < 20; k++) begin
            tick(0, 0, 1, 0);
            chk("drain_no_valid", 32'(valid[1]), 32'd0);
        end
        tick(0, 1, 1, 0);
        chk("drain_inval_op", {valid[1], op[1]}, {1'b1, FLUSH_INVAL_ALL});
        tick(0, 1, 1, 0);
        tick(0, 1, 1, 1);
        tick(0, 1, 1, 0);

        // no flush on fence: immediate ack; then timeout on the flushing instance
        tick(1, 1, 1, 0);
        chk("nofof_ack", {ack[2], busy[2]}, 2'b11);
        tick(0, 1, 1, 0);
        chk("nofof_ack_once", 32'(ack[2]), 32'd0);
        tick(0, 1, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            tick(0, 1, 1, 0);
            if (k == 7) chk("tmo_before", 32'(tmo[0]), 32'd0);
            if (k == 8) chk("tmo_after", 32'(tmo[0]), 32'd1);
        end
        tick(0, 1, 1, 1);
        chk("tmo_late_ack", 32'(ack[0]), 32'd1);
        tick(0, 1, 1, 0);
        tick(0, 1, 1, 1);
        chk("spurious_perr", 32'(perr[0]), 32'd1);
        tick(0, 1, 1, 0);

        // asynchronous reset while waiting for the response
        tick(1, 1, 1, 0);
        tick(0, 1, 1, 0);
        tick(0, 1, 1, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("async_rst_d%0d", i), 32'(dut_vec(i)), 32'd0);
        tick(0, 1, 1, 1);
        tick(0, 1, 1, 1);
        rst_n = 1'b1;
        ack_seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick(0, 1, 1, 0);
            ack_seen |= ack[0];
        end
        chk("no_ack_after_rst", 32'(ack_seen), 32'd0);

        for (int k = 0; k < 400; k++)
            tick($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);

        chk("nofof_never_valid", 32'(d2_valid_seen), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
